// File: rtl/snake_pkg.sv
// snake_pkg: shared board geometry, controller states and body-bus segment extraction
package snake_pkg;
  localparam int COORD_W = 3;
  localparam int GRID_W = 8;
  localparam int GRID_CELLS = 64;
  localparam int MAX_LEN_DEF = 16;
  localparam int FLAT_MAX = COORD_W * GRID_CELLS;
  typedef enum logic [2:0] {IDLE, REQ, WAIT, LATCH, CHECK, SCAN, COMMIT} state_e;
  function automatic logic [COORD_W-1:0] seg_at(input logic [FLAT_MAX-1:0] flat, input int i);
    return flat[COORD_W*i +: COORD_W];
  endfunction
endpackage

// File: rtl/food_spawner_if.sv
// food_spawner_if: spawn request, snake body, generator and food-register signals
interface food_spawner_if
  import snake_pkg::*;
#(parameter int MAX_LEN = MAX_LEN_DEF);
  logic spawn_req;
  logic [COORD_W*MAX_LEN-1:0] snake_x_flat, snake_y_flat;
  logic [4:0] snake_len;
  logic [COORD_W-1:0] rand_x, rand_y;
  logic rand_en;
  logic [COORD_W-1:0] food_x, food_y;
  logic food_valid, busy, done, fail;
  modport master(output spawn_req, snake_x_flat, snake_y_flat, snake_len, rand_x, rand_y,
                 input rand_en, food_x, food_y, food_valid, busy, done, fail);
  modport slave(input spawn_req, snake_x_flat, snake_y_flat, snake_len, rand_x, rand_y,
                output rand_en, food_x, food_y, food_valid, busy, done, fail);
endinterface

// File: rtl/food_spawner_cell_occupied.sv
// cell_occupied: flags a board cell that matches any of the first len body segments
module cell_occupied
  import snake_pkg::*;
#(parameter int MAX_LEN = MAX_LEN_DEF) (
  input  logic [COORD_W-1:0] cell_x,
  input  logic [COORD_W-1:0] cell_y,
  input  logic [COORD_W*MAX_LEN-1:0] x_flat,
  input  logic [COORD_W*MAX_LEN-1:0] y_flat,
  input  logic [4:0] len,
  output logic hit
);
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < MAX_LEN; i++)
      hit = hit | ((5'(i) < len) && seg_at(FLAT_MAX'(x_flat), i) == cell_x && seg_at(FLAT_MAX'(y_flat), i) == cell_y);
  end
endmodule

// File: rtl/food_spawner.sv
// food_spawner: places food on a free board cell using the random generator; FALLBACK_SCAN_EN adds an exhaustive scan after MAX_TRIES collisions
module food_spawner
  import snake_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int MAX_TRIES = 8,
  parameter int INIT_X = 5,
  parameter int INIT_Y = 5
) (
  input logic clk,
  input logic rst,
  food_spawner_if.slave bus
);
  state_e state_q, state_d;
  logic [4:0] idx_q, idx_d, len_eff;
  logic [3:0] tries_q, tries_d;
  logic [5:0] c_q, c_d;
  logic [COORD_W-1:0] cand_x_q, cand_x_d, cand_y_q, cand_y_d;
  logic [COORD_W-1:0] food_x_q, food_x_d, food_y_q, food_y_d, cx, cy;
  logic food_valid_q, food_valid_d, busy_q, busy_d, done_q, done_d, fail_q, fail_d;
  logic rand_en_q, rand_en_d, commit, give_up, seg_hit, hit;
  assign len_eff = bus.snake_len > 5'(MAX_LEN) ? 5'(MAX_LEN) : bus.snake_len;
  assign seg_hit = seg_at(FLAT_MAX'(bus.snake_x_flat), int'(idx_q)) == cand_x_q &&
                   seg_at(FLAT_MAX'(bus.snake_y_flat), int'(idx_q)) == cand_y_q;
  cell_occupied #(.MAX_LEN(MAX_LEN)) u_occ (
    .cell_x(c_q[2:0]), .cell_y(c_q[5:3]),
    .x_flat(bus.snake_x_flat), .y_flat(bus.snake_y_flat),
    .len(len_eff), .hit(hit)
  );
`ifndef FALLBACK_SCAN_EN
  logic unused;
  assign unused = hit ^ (MAX_TRIES == 0);
`endif
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    tries_d = tries_q;
    c_d = c_q;
    cand_x_d = cand_x_q;
    cand_y_d = cand_y_q;
    food_x_d = food_x_q;
    food_y_d = food_y_q;
    food_valid_d = food_valid_q;
    busy_d = busy_q;
    done_d = 1'b0;
    fail_d = 1'b0;
    commit = 1'b0;
    give_up = 1'b0;
    cx = cand_x_q;
    cy = cand_y_q;
    case (state_q)
      IDLE: if (bus.spawn_req) begin
        state_d = REQ;
        busy_d = 1'b1;
        food_valid_d = 1'b0;
        tries_d = '0;
      end
      REQ: state_d = WAIT;
      WAIT: state_d = LATCH;
      LATCH: begin
        cand_x_d = bus.rand_x;
        cand_y_d = bus.rand_y;
        idx_d = '0;
        state_d = CHECK;
        commit = len_eff == '0;
        cx = bus.rand_x;
        cy = bus.rand_y;
      end
      CHECK: if (seg_hit) begin
        tries_d = &tries_q ? tries_q : tries_q + 4'd1;
        state_d = REQ;
`ifdef FALLBACK_SCAN_EN
        if (tries_q == 4'(MAX_TRIES - 1)) begin
          state_d = SCAN;
          c_d = '0;
        end
`endif
      end else if (idx_q == len_eff - 5'd1) commit = 1'b1;
      else idx_d = idx_q + 5'd1;
`ifdef FALLBACK_SCAN_EN
      SCAN: if (!hit) begin
        commit = 1'b1;
        cx = c_q[2:0];
        cy = c_q[5:3];
      end else if (&c_q) give_up = 1'b1;
      else c_d = c_q + 6'd1;
`endif
      COMMIT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // done/fail are registered on entry to COMMIT so the pulse coincides with the new food value
    if (commit || give_up) begin
      food_x_d = commit ? cx : food_x_q;
      food_y_d = commit ? cy : food_y_q;
      food_valid_d = commit;
      done_d = 1'b1;
      fail_d = give_up;
      busy_d = 1'b0;
      state_d = COMMIT;
    end
    rand_en_d = state_d == REQ;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      tries_q <= '0;
      c_q <= '0;
      cand_x_q <= '0;
      cand_y_q <= '0;
      food_x_q <= COORD_W'(INIT_X);
      food_y_q <= COORD_W'(INIT_Y);
      food_valid_q <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      fail_q <= 1'b0;
      rand_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      tries_q <= tries_d;
      c_q <= c_d;
      cand_x_q <= cand_x_d;
      cand_y_q <= cand_y_d;
      food_x_q <= food_x_d;
      food_y_q <= food_y_d;
      food_valid_q <= food_valid_d;
      busy_q <= busy_d;
      done_q <= done_d;
      fail_q <= fail_d;
      rand_en_q <= rand_en_d;
    end
  end
  assign bus.rand_en = rand_en_q;
  assign bus.food_x = food_x_q;
  assign bus.food_y = food_y_q;
  assign bus.food_valid = food_valid_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.fail = fail_q;
endmodule

// File: doc/food_spawner.md
Name: food_spawner

Overview:
- Controller that sequences the pseudo-random coordinate generator to place a new food cell on the 8x8 board.
- On a spawn request it pulses the generator, latches a candidate (x,y) and walks the snake body one segment per cycle to reject occupied cells.
- Retries on collision; commits the first free candidate to the food register.
- Sits between the game-logic FSM (which asserts spawn_req when food is eaten) and the random generator and renderer.

Parameters:
- MAX_LEN, 16, number of snake segment slots on the body buses.
- MAX_TRIES, 8, random candidates attempted before fallback scan (used only with FALLBACK_SCAN_EN).
- INIT_X, 5, food x after reset.
- INIT_Y, 5, food y after reset.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- spawn_req  in  1  one-cycle request to place new food
- snake_x_flat  in  3*MAX_LEN  segment x coords; segment i at [3i+2:3i], i=0 is head
- snake_y_flat  in  3*MAX_LEN  segment y coords, same packing
- snake_len  in  5  number of valid segments, 0..MAX_LEN
- rand_x  in  3  generator output x, registered by generator
- rand_y  in  3  generator output y
- rand_en  out  1  one-cycle strobe to the generator to advance
- food_x  out  3  committed food x
- food_y  out  3  committed food y
- food_valid  out  1  food register holds a placed cell
- busy  out  1  placement in progress
- done  out  1  one-cycle pulse when placement ends
- fail  out  1  one-cycle pulse with done when no free cell exists

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- Reset values: food_x=INIT_X, food_y=INIT_Y, food_valid=1, busy=0, done=0, fail=0, rand_en=0, state=IDLE, tries=0.
- Reset mid-operation aborts to IDLE with the reset values above; no done pulse is issued.
- States: IDLE, REQ, WAIT, LATCH, CHECK, SCAN, COMMIT.
- IDLE:
  - spawn_req=1 -> REQ; busy=1, food_valid=0, tries=0.
  - spawn_req while busy is ignored (not queued).
- REQ: rand_en=1 for exactly this cycle -> WAIT.
- WAIT: one cycle for the generator register to update -> LATCH.
- LATCH: cand <= {rand_x, rand_y}; idx=0 -> CHECK.
- CHECK: compare segment idx to cand each cycle.
  - Match: tries++ (saturating 4-bit) -> REQ; with FALLBACK_SCAN_EN and tries==MAX_TRIES-1 -> SCAN instead.
  - No match and idx==L-1 -> COMMIT; otherwise idx++.
- L = min(snake_len, MAX_LEN). L=0 -> LATCH goes directly to COMMIT.
- COMMIT: food <= cand, food_valid=1, done=1, busy=0 -> IDLE.
- Latency without collision: spawn_req sampled at edge T -> done/food_valid high in cycle T+4+L. Each collision adds 3+(idx+1) cycles.
- Body buses and snake_len must be held stable while busy; behaviour with changing inputs is undefined. The bench must not do this.
- Arithmetic:
  - Coordinates are 3-bit unsigned, no wrap arithmetic.
  - Segment compare is full 6-bit equality.
  - Segments at index >= L are never compared.

Optional Feature:
- Macro FALLBACK_SCAN_EN.
- Defined:
  - After MAX_TRIES collisions, enter SCAN with cell counter c=0..63, x=c[2:0], y=c[5:3].
  - One cell per cycle; occupancy is tested against all L segments combinationally.
  - First free cell -> cand=cell -> COMMIT.
  - c=63 occupied -> done=1, fail=1, food_valid=0, busy=0 -> IDLE.
- Undefined:
  - No SCAN state; retries indefinitely and fail is tied 0.
  - Termination relies on the generator eventually producing a free cell.

Decomposition:
- Shared package snake_pkg:
  - COORD_W=3, GRID_W=8, GRID_CELLS=64.
  - MAX_LEN default.
  - State encoding localparams.
  - Segment-extract function (index -> 3-bit slice).
- One sub-module, cell_occupied: combinational. Inputs: cell x/y, flat body, L. Output: hit if any valid segment equals the cell. Used by SCAN; CHECK uses a single indexed comparator.

Test Plan:
- Reset then idle 5 cycles -> food=(5,5), food_valid=1, busy=0, rand_en never high.
- snake_len=3 body {(0,0),(1,0),(2,0)}, rand stub returns (4,6), spawn_req at T -> rand_en at T+1, done at T+7, food=(4,6), fail=0.
- Stub returns (1,0) then (7,7) -> exactly two rand_en pulses, food=(7,7), done at T+12.
- spawn_req pulsed again while busy -> single done; rst asserted during CHECK -> next cycle food=(5,5), busy=0, no done.
- snake_len=0 -> done at T+4 with stub value.
- FALLBACK_SCAN_EN, MAX_TRIES=2, stub always (0,0), body occupies (0,0),(1,0) -> SCAN commits (2,0), fail=0. Without the macro -> busy stays 1 for 200 cycles.
